phys_free_list: RTL and testbench

PHYS_FREE_LIST -- requirements
Module: phys_free_list

---
 rtl/phys_free_list_pkg.sv | 10 +
 rtl/phys_free_list.sv | 103 ++++++++++
 tb/tb_phys_free_list.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/phys_free_list_pkg.sv
// Shared rename-stage constants: physical/architectural register counts
// and the physical register index width, common to the register file,
// the map table and the free list.
package phys_free_list_pkg;

  localparam int unsigned RN_NUM_PHYS_REGS = 64;
  localparam int unsigned RN_NUM_ARCH_REGS = 32;
  localparam int unsigned RN_LOG_PHYS      = $clog2(RN_NUM_PHYS_REGS);

endpackage : phys_free_list_pkg

// File: rtl/phys_free_list.sv
// Physical register free list: circular FIFO of free physical register
// tags. Head hands out tags at rename, tail accepts tags returned at
// commit, and retire_head tracks the non-speculative head so a flush can
// return every speculative allocation in one cycle.
module phys_free_list
  import phys_free_list_pkg::*;
#(
  parameter  int unsigned NUM_PHYS_REGS = RN_NUM_PHYS_REGS,
  parameter  int unsigned NUM_ARCH_REGS = RN_NUM_ARCH_REGS,
  localparam int unsigned LOG_PHYS      = $clog2(NUM_PHYS_REGS)
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                Alloc_IN,
  output logic [LOG_PHYS-1:0] AllocReg_OUT,
  output logic                AllocValid_OUT,
  output logic                SetBusy_OUT,
  output logic [LOG_PHYS-1:0] BusyReg_OUT,
  input  logic                Free_IN,
  input  logic [LOG_PHYS-1:0] FreeReg_IN,
  input  logic                Retire_IN,
  input  logic                Flush_IN,
  output logic [LOG_PHYS:0]   FreeCount_OUT,
  output logic                Overflow_OUT
);

  typedef logic [LOG_PHYS-1:0] idx_t;
  typedef logic [LOG_PHYS:0]   ptr_t;

  // Most free entries the list can ever legally hold.
  localparam ptr_t FREE_CAP = ptr_t'(NUM_PHYS_REGS - NUM_ARCH_REGS);

  // Pointers carry a wrap bit, so plain +1 wraps at 2^(LOG_PHYS+1).
  function automatic ptr_t ptr_inc(input ptr_t p);
    return p + ptr_t'(1);
  endfunction

  idx_t buf_q [NUM_PHYS_REGS];
  ptr_t head_q, head_d;
  ptr_t retire_head_q, retire_head_d;
  ptr_t tail_q, tail_d;
  logic overflow_q, overflow_d;

  ptr_t free_count;
  logic alloc_valid;
  logic grant;
  logic retire_ok;
  logic overflow_hit;
  logic free_ok;

  // Next-state pointer and flag logic.
  always_comb begin
    free_count    = tail_q - head_q;
    alloc_valid   = (free_count != '0);
    grant         = Alloc_IN & alloc_valid & ~Flush_IN;
    retire_ok     = Retire_IN & (retire_head_q != head_q);
    // A return is only dropped when the list is at capacity and no tag
    // leaves in the same cycle.
    overflow_hit  = Free_IN & (free_count == FREE_CAP) & ~grant;
    free_ok       = Free_IN & ~overflow_hit;
    retire_head_d = retire_ok ? ptr_inc(retire_head_q) : retire_head_q;
    // Flush rewinds to the committed head, including a retire this cycle.
    if (Flush_IN)   head_d = retire_head_d;
    else if (grant) head_d = ptr_inc(head_q);
    else            head_d = head_q;
    tail_d        = free_ok ? ptr_inc(tail_q) : tail_q;
    overflow_d    = overflow_q | overflow_hit;
  end

  // Pointer and sticky-flag registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      head_q        <= '0;
      retire_head_q <= '0;
      tail_q        <= FREE_CAP;
      overflow_q    <= 1'b0;
    end else begin
      head_q        <= head_d;
      retire_head_q <= retire_head_d;
      tail_q        <= tail_d;
      overflow_q    <= overflow_d;
    end
  end

  // Tag storage: reset seeds the non-architectural tags, returns write at tail.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int unsigned i = 0; i < NUM_PHYS_REGS - NUM_ARCH_REGS; i++) begin
        buf_q[i] <= idx_t'(NUM_ARCH_REGS + i);
      end
    end else if (free_ok) begin
      buf_q[tail_q[LOG_PHYS-1:0]] <= FreeReg_IN;
    end
  end

  assign AllocReg_OUT   = buf_q[head_q[LOG_PHYS-1:0]];
  assign AllocValid_OUT = alloc_valid;
  assign SetBusy_OUT    = grant;
  assign BusyReg_OUT    = AllocReg_OUT;
  assign FreeCount_OUT  = free_count;
  assign Overflow_OUT   = overflow_q;

endmodule : phys_free_list

// File: tb/tb_phys_free_list.sv
// Directed bench for phys_free_list with hand-computed expectations.
module tb_phys_free_list;

  logic       CLK;
  logic       RESET;
  logic       Alloc_IN;
  logic [5:0] AllocReg_OUT;
  logic       AllocValid_OUT;
  logic       SetBusy_OUT;
  logic [5:0] BusyReg_OUT;
  logic       Free_IN;
  logic [5:0] FreeReg_IN;
  logic       Retire_IN;
  logic       Flush_IN;
  logic [6:0] FreeCount_OUT;
  logic       Overflow_OUT;

  int unsigned n_checks;
  int unsigned n_pass;

  phys_free_list #(
    .NUM_PHYS_REGS(64),
    .NUM_ARCH_REGS(32)
  ) dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .Alloc_IN      (Alloc_IN),
    .AllocReg_OUT  (AllocReg_OUT),
    .AllocValid_OUT(AllocValid_OUT),
    .SetBusy_OUT   (SetBusy_OUT),
    .BusyReg_OUT   (BusyReg_OUT),
    .Free_IN       (Free_IN),
    .FreeReg_IN    (FreeReg_IN),
    .Retire_IN     (Retire_IN),
    .Flush_IN      (Flush_IN),
    .FreeCount_OUT (FreeCount_OUT),
    .Overflow_OUT  (Overflow_OUT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    Alloc_IN = 1'b0; Free_IN = 1'b0; FreeReg_IN = '0;
    Retire_IN = 1'b0; Flush_IN = 1'b0;
  endtask

  // Reset with every other control asserted; reset must win.
  task automatic do_reset();
    RESET = 1'b1; Alloc_IN = 1'b1; Free_IN = 1'b1; FreeReg_IN = 6'd9;
    Retire_IN = 1'b1; Flush_IN = 1'b1;
    tick();
    RESET = 1'b0;
    idle();
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    idle();
    RESET = 1'b0;

    // Reset state
    do_reset();
    check("rst_count", FreeCount_OUT, 32);
    check("rst_valid", AllocValid_OUT, 1);
    check("rst_reg", AllocReg_OUT, 32);
    check("rst_busy", SetBusy_OUT, 0);
    check("rst_ovf", Overflow_OUT, 0);

    // Drain all 32 free tags
    for (int i = 0; i < 32; i++) begin
      Alloc_IN = 1'b1;
      #1;
      check("drain_busy", SetBusy_OUT, 1);
      check("drain_reg", BusyReg_OUT, 32 + i);
      tick();
    end
    check("empty_valid", AllocValid_OUT, 0);
    check("empty_count", FreeCount_OUT, 0);
    check("empty_busy", SetBusy_OUT, 0);
    tick();
    check("empty_hold", FreeCount_OUT, 0);

    // Free on empty list is not bypassed to the same-cycle alloc
    Alloc_IN = 1'b1; Free_IN = 1'b1; FreeReg_IN = 6'd5;
    #1;
    check("nobypass_busy", SetBusy_OUT, 0);
    tick();
    Free_IN = 1'b0;
    #1;
    check("bypass_next_busy", SetBusy_OUT, 1);
    check("bypass_next_reg", BusyReg_OUT, 5);
    check("bypass_next_cnt", FreeCount_OUT, 1);
    tick();
    Alloc_IN = 1'b0;
    #1;
    check("bypass_after_cnt", FreeCount_OUT, 0);

    // Alloc 4, retire 2, flush: head back to 2
    do_reset();
    for (int i = 0; i < 4; i++) begin
      Alloc_IN = 1'b1;
      #1;
      check("a4_reg", BusyReg_OUT, 32 + i);
      tick();
    end
    Alloc_IN = 1'b0; Retire_IN = 1'b1;
    tick(); tick();
    Retire_IN = 1'b0; Flush_IN = 1'b1;
    tick();
    Flush_IN = 1'b0;
    #1;
    check("flush_count", FreeCount_OUT, 30);
    Alloc_IN = 1'b1;
    #1;
    check("flush_next_busy", SetBusy_OUT, 1);
    check("flush_next_reg", BusyReg_OUT, 34);
    tick();
    Alloc_IN = 1'b0;

    // Flush + retire + alloc after 3 allocations
    do_reset();
    Alloc_IN = 1'b1;
    tick(); tick(); tick();
    Flush_IN = 1'b1; Retire_IN = 1'b1;
    #1;
    check("fra_busy", SetBusy_OUT, 0);
    tick();
    idle();
    #1;
    check("fra_count", FreeCount_OUT, 31);
    check("fra_head_reg", AllocReg_OUT, 33);

    // Overflow: free while full
    do_reset();
    Free_IN = 1'b1; FreeReg_IN = 6'd7;
    tick();
    Free_IN = 1'b0;
    #1;
    check("ovf_set", Overflow_OUT, 1);
    check("ovf_count", FreeCount_OUT, 32);
    check("ovf_head_reg", AllocReg_OUT, 32);
    Alloc_IN = 1'b1;
    tick();
    Alloc_IN = 1'b0; Free_IN = 1'b1; FreeReg_IN = 6'd32;
    tick();
    Free_IN = 1'b0;
    #1;
    check("ovf_sticky", Overflow_OUT, 1);
    check("ovf_refill_cnt", FreeCount_OUT, 32);
    do_reset();
    check("ovf_cleared", Overflow_OUT, 0);

    // 64 simultaneous grant+free cycles: wrap, steady count, FIFO order
    for (int i = 0; i < 64; i++) begin
      Alloc_IN = 1'b1; Free_IN = 1'b1; FreeReg_IN = 6'(32 + (i % 32));
      #1;
      check("wrap_busy", SetBusy_OUT, 1);
      check("wrap_reg", BusyReg_OUT, 32 + (i % 32));
      tick();
      check("wrap_count", FreeCount_OUT, 32);
    end
    idle();
    #1;
    check("wrap_ovf", Overflow_OUT, 0);
    check("wrap_head_reg", AllocReg_OUT, 32);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_phys_free_list
